// File: rtl/rom_scan_reader.sv
// rom_scan_reader
//   Reads a parallel ROM chip (556PT5/3604 by default, 556PT4/3601 with
//   DATA_WIDTH=4, ADDRESS_WIDTH=8) either one address per key press
//   (manual) or as a full sequential dump (auto). After every address change
//   it waits ACCESS_CYCLES clocks, samples the chip data pins and emits a
//   one-cycle data_valid strobe.
//
// Ports
//   clk                system clock
//   reset_n            synchronous reset, ACTIVE HIGH (1 = reset); the name
//                      is kept for top-level compatibility
//   mode               0 = manual, 1 = auto scan (acted on only in IDLE)
//   start              auto-scan request level (acted on only in IDLE)
//   increment_address  manual step up key level, rising edge acts
//   decrement_address  manual step down key level, rising edge acts
//   data_line_in       data pins from the chip
//   operation          V1..V4 control code to the chip (bit0 = V1)
//   address_line       address pins to the chip
//   data_line          last sampled word, held between strobes
//   data_valid         one-cycle strobe: data_line updated this cycle
//   busy               high while settling or sampling
//   done               one-cycle strobe at the end of an auto scan

module rom_scan_reader #(
    parameter int          DATA_WIDTH    = 8,
    parameter int          ADDRESS_WIDTH = 9,
    parameter int          ACCESS_CYCLES = 4,
    parameter logic [3:0]  OP_READ       = 4'b1100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mode,
    input  logic                     start,
    input  logic                     increment_address,
    input  logic                     decrement_address,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_line,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        ADDR_HOLD,
        ADDR_ZERO,
        ADDR_INC,
        ADDR_DEC
    } addr_op_t;

    localparam logic [7:0]               CNT_RELOAD = 8'(ACCESS_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX   = '1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE   = ADDRESS_WIDTH'(1);

    state_t   state;
    state_t   state_next;
    addr_op_t addr_op;

    logic [7:0] cnt;
    logic       scan;
    logic       inc_q;
    logic       dec_q;
    logic       armed;
    logic       inc_edge;
    logic       dec_edge;

    logic       cnt_load;
    logic       capture;
    logic       scan_set;
    logic       scan_clr;
    logic       done_set;

    // armed stays low for the first clock after reset so that a key held
    // through reset (inc_q/dec_q cleared to 0) is not mistaken for a press.
    assign inc_edge = armed & increment_address & ~inc_q;
    assign dec_edge = armed & decrement_address & ~dec_q;

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        addr_op    = ADDR_HOLD;
        cnt_load   = 1'b0;
        capture    = 1'b0;
        scan_set   = 1'b0;
        scan_clr   = 1'b0;
        done_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mode && start) begin
                    addr_op    = ADDR_ZERO;
                    cnt_load   = 1'b1;
                    scan_set   = 1'b1;
                    state_next = ST_SETTLE;
                end else if (!mode && inc_edge && !dec_edge) begin
                    addr_op    = ADDR_INC;
                    cnt_load   = 1'b1;
                    state_next = ST_SETTLE;
                end else if (!mode && dec_edge && !inc_edge) begin
                    addr_op    = ADDR_DEC;
                    cnt_load   = 1'b1;
                    state_next = ST_SETTLE;
                end
                // Both edges together: ambiguous request, ignored.
            end

            ST_SETTLE: begin
                if (cnt == 8'd0) begin
                    state_next = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                capture = 1'b1;
                if (!scan) begin
                    state_next = ST_IDLE;
                end else if (address_line == ADDR_MAX) begin
                    state_next = ST_DONE;
                end else begin
                    // The address step here starts the next access window.
                    addr_op    = ADDR_INC;
                    cnt_load   = 1'b1;
                    state_next = ST_SETTLE;
                end
            end

            ST_DONE: begin
                done_set   = 1'b1;
                scan_clr   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            operation    <= 4'b0000;
            address_line <= '0;
            data_line    <= '0;
            data_valid   <= 1'b0;
            done         <= 1'b0;
            cnt          <= 8'd0;
            scan         <= 1'b0;
            inc_q        <= 1'b0;
            dec_q        <= 1'b0;
            armed        <= 1'b0;
        end else begin
            operation <= OP_READ;
            inc_q     <= increment_address;
            dec_q     <= decrement_address;
            armed     <= 1'b1;

            case (addr_op)
                ADDR_ZERO: address_line <= '0;
                ADDR_INC:  address_line <= address_line + ADDR_ONE;
                ADDR_DEC:  address_line <= address_line - ADDR_ONE;
                default:   address_line <= address_line;
            endcase

            if (cnt_load) begin
                cnt <= CNT_RELOAD;
            end else if (state == ST_SETTLE && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            if (capture) begin
                data_line <= data_line_in;
            end
            data_valid <= capture;
            done       <= done_set;

            if (scan_set) begin
                scan <= 1'b1;
            end else if (scan_clr) begin
                scan <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Testbench for rom_scan_reader.
//   dut_a: default 3604 geometry (9-bit address, 8-bit data, 4 access cycles),
//          manual stepping against a ROM whose word is addr ^ 8'hA5.
//   dut_b: 3601 geometry (8-bit address, 4-bit data, 1 access cycle),
//          auto scans against a ROM filled with random words.
// Stimulus pushes expected strobes (data, address, cycle of arrival) into a
// queue per DUT; a monitor per DUT pops and compares on every data_valid.

module tb_rom_scan_reader;

    localparam int ACC_A  = 4;
    localparam int AW_A   = 9;
    localparam int DW_A   = 8;
    localparam int SIZE_A = 1 << AW_A;
    localparam int ACC_B  = 1;
    localparam int AW_B   = 8;
    localparam int DW_B   = 4;
    localparam int SIZE_B = 1 << AW_B;

    typedef struct {
        longint data;
        longint addr;
        bit     chk_addr;
        longint cyc;
    } exp_t;

    logic clk;
    longint cyc;
    int vectors;
    int miscompares;

    exp_t q_a[$];
    exp_t q_b[$];
    int   done_cnt_b;
    longint exp_addr_a;
    longint last_data_a;

    // dut_a signals
    logic            rst_a, mode_a, start_a, inc_a, dec_a;
    logic [DW_A-1:0] din_a, dout_a;
    logic [3:0]      op_a;
    logic [AW_A-1:0] addr_a;
    logic            dv_a, busy_a, done_a;

    // dut_b signals
    logic            rst_b, mode_b, start_b, inc_b, dec_b;
    logic [DW_B-1:0] din_b, dout_b;
    logic [3:0]      op_b;
    logic [AW_B-1:0] addr_b;
    logic            dv_b, busy_b, done_b;

    logic [DW_B-1:0] rom_b [SIZE_B];

    assign din_a = addr_a[7:0] ^ 8'hA5;
    assign din_b = rom_b[addr_b];

    rom_scan_reader dut_a (
        .clk               (clk),
        .reset_n           (rst_a),
        .mode              (mode_a),
        .start             (start_a),
        .increment_address (inc_a),
        .decrement_address (dec_a),
        .data_line_in      (din_a),
        .operation         (op_a),
        .address_line      (addr_a),
        .data_line         (dout_a),
        .data_valid        (dv_a),
        .busy              (busy_a),
        .done              (done_a)
    );

    rom_scan_reader #(
        .DATA_WIDTH    (DW_B),
        .ADDRESS_WIDTH (AW_B),
        .ACCESS_CYCLES (ACC_B)
    ) dut_b (
        .clk               (clk),
        .reset_n           (rst_b),
        .mode              (mode_b),
        .start             (start_b),
        .increment_address (inc_b),
        .decrement_address (dec_b),
        .data_line_in      (din_b),
        .operation         (op_b),
        .address_line      (addr_b),
        .data_line         (dout_b),
        .data_valid        (dv_b),
        .busy              (busy_b),
        .done              (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dv_a) begin
            if (q_a.size() == 0) begin
                check("a_spurious_strobe", dv_a, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_data", dout_a, e.data);
                if (e.chk_addr) check("a_strobe_addr", addr_a, e.addr);
                check("a_strobe_cycle", cyc, e.cyc);
            end
        end
        if (done_a) check("a_spurious_done", done_a, 0);
    end

    always @(negedge clk) begin
        if (dv_b) begin
            if (q_b.size() == 0) begin
                check("b_spurious_strobe", dv_b, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_data", dout_b, e.data);
                check("b_strobe_cycle", cyc, e.cyc);
            end
        end
        if (done_b) done_cnt_b++;
    end

    // One manual key press on dut_a. With double_tap a second rising edge is
    // made while the first access is still settling; it must be dropped.
    task automatic press_a(input bit up, input bit double_tap);
        exp_t e;
        @(posedge clk); #1;
        if (up) inc_a = 1'b1; else dec_a = 1'b1;
        exp_addr_a  = up ? (exp_addr_a + 1) % SIZE_A : (exp_addr_a + SIZE_A - 1) % SIZE_A;
        last_data_a = (exp_addr_a & 255) ^ 'hA5;
        e.data      = last_data_a;
        e.addr      = exp_addr_a;
        e.chk_addr  = 1'b1;
        e.cyc       = cyc + ACC_A + 2;
        q_a.push_back(e);
        @(posedge clk); #1;
        check("a_addr_after_press", addr_a, exp_addr_a);
        check("a_busy_settle", busy_a, 1);
        if (double_tap) begin
            @(posedge clk); #1;
            inc_a = 1'b0; dec_a = 1'b0;
            @(posedge clk); #1;
            if (up) inc_a = 1'b1; else dec_a = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        inc_a = 1'b0; dec_a = 1'b0;
        repeat (ACC_A + 3) @(posedge clk);
        #1;
        check("a_addr_idle", addr_a, exp_addr_a);
    endtask

    // Start an auto scan on dut_b and queue all expected strobes.
    task automatic scan_b();
        exp_t e;
        longint k;
        @(posedge clk); #1;
        start_b = 1'b1;
        k = cyc;
        for (int i = 0; i < SIZE_B; i++) begin
            e.data     = rom_b[i];
            e.addr     = i;
            e.chk_addr = 1'b0;
            e.cyc      = k + 1 + (i + 1) * (ACC_B + 1);
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    initial begin
        int  d0;
        bit  found;

        vectors     = 0;
        miscompares = 0;
        done_cnt_b  = 0;
        exp_addr_a  = 0;
        last_data_a = 0;
        for (int i = 0; i < SIZE_B; i++) rom_b[i] = DW_B'($urandom);

        rst_a = 1'b1; mode_a = 1'b0; start_a = 1'b0; inc_a = 1'b1; dec_a = 1'b0;
        rst_b = 1'b1; mode_b = 1'b1; start_b = 1'b0; inc_b = 1'b0; dec_b = 1'b0;

        // Reset with the increment key held down.
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_op", op_a, 0);
        check("a_reset_addr", addr_a, 0);
        check("a_reset_data", dout_a, 0);
        check("a_reset_dv", dv_a, 0);
        check("a_reset_busy", busy_a, 0);
        check("a_reset_done", done_a, 0);
        check("b_reset_op", op_b, 0);
        check("b_reset_addr", addr_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("a_op_after_release", op_a, 'b1100);
        check("b_op_after_release", op_b, 'b1100);
        repeat (ACC_A + 4) @(posedge clk);
        #1;
        check("a_addr_key_held_through_reset", addr_a, 0);
        inc_a = 1'b0;
        repeat (2) @(posedge clk);

        // Manual stepping: second press while settling is ignored; wraps.
        press_a(1'b1, 1'b1);   // 0 -> 1, data A4
        press_a(1'b0, 1'b0);   // 1 -> 0
        press_a(1'b0, 1'b0);   // 0 -> 511, data 5A
        press_a(1'b1, 1'b0);   // 511 -> 0

        // Simultaneous rising edges: no step, no strobe.
        @(posedge clk); #1;
        inc_a = 1'b1; dec_a = 1'b1;
        repeat (ACC_A + 4) @(posedge clk);
        #1;
        check("a_addr_simultaneous", addr_a, exp_addr_a);
        inc_a = 1'b0; dec_a = 1'b0;
        repeat (2) @(posedge clk);

        // Random manual walk.
        for (int i = 0; i < 24; i++) begin
            press_a(1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        #1;
        check("a_data_held", dout_a, last_data_a);
        check("a_queue_drained", q_a.size(), 0);

        // Full auto scan.
        scan_b();
        repeat (SIZE_B * (ACC_B + 1) + 6) @(posedge clk);
        #1;
        check("b_scan_queue_drained", q_b.size(), 0);
        check("b_done_count", done_cnt_b, 1);
        check("b_busy_after_done", busy_b, 0);
        check("b_addr_after_done", addr_b, SIZE_B - 1);

        // Reset in the middle of a scan.
        scan_b();
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk); #1;
            if (addr_b == 100) found = 1'b1;
        end
        check("b_reached_addr_100", found, 1);
        @(negedge clk); #1;
        rst_b = 1'b1;
        q_b.delete();
        d0 = done_cnt_b;
        @(posedge clk); #1;
        check("b_midreset_op", op_b, 0);
        check("b_midreset_addr", addr_b, 0);
        check("b_midreset_data", dout_b, 0);
        check("b_midreset_dv", dv_b, 0);
        check("b_midreset_busy", busy_b, 0);
        check("b_midreset_done", done_b, 0);
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b_no_done_after_abort", done_cnt_b, d0);

        // A fresh scan restarts from address 0.
        scan_b();
        repeat (SIZE_B * (ACC_B + 1) + 6) @(posedge clk);
        #1;
        check("b_rescan_queue_drained", q_b.size(), 0);
        check("b_rescan_done_count", done_cnt_b, d0 + 1);
        check("b_rescan_busy", busy_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
